// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter for the shared internal bus.
// Each grant has a watchdog that force-releases a hung master.
// After every release the bus stays idle for a drain window, so a late
// slave ACK is never routed to the next master.

module wb_rr_arbiter #(
    parameter int NUM_OF_MASTER   = 5,
    parameter int NUM_OF_SEL_BITS = 3,
    parameter int DRAIN_CYCLES    = 2,
    parameter int TIMEOUT         = 64
) (
    input  logic                       CLK_I,
    input  logic                       RST_I,
    input  logic [NUM_OF_MASTER-1:0]   CYC_I,
    input  logic                       ACK_I,
    output logic [NUM_OF_SEL_BITS-1:0] GNT,
    output logic [NUM_OF_MASTER-1:0]   GNT_mux,
    output logic                       CYC,
    output logic                       timeout,
    output logic [7:0]                 timeout_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [NUM_OF_SEL_BITS-1:0] LAST_MASTER = NUM_OF_SEL_BITS'(NUM_OF_MASTER - 1);
    localparam logic [15:0] DRAIN_LOAD = (DRAIN_CYCLES == 0) ? 16'd0 : 16'(DRAIN_CYCLES - 1);
    localparam logic [15:0] WD_LIMIT   = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);
    localparam bit          WD_ENABLE  = (TIMEOUT != 0);
    localparam bit          NO_DRAIN   = (DRAIN_CYCLES == 0);

    state_t                     state;
    logic [NUM_OF_SEL_BITS-1:0] ptr;
    logic [15:0]                watchdog;
    logic [15:0]                drain;
    logic [NUM_OF_MASTER-1:0]   lockout;

    logic [NUM_OF_MASTER-1:0]   eligible;
    logic                       found;
    logic [NUM_OF_SEL_BITS-1:0] pick;
    logic [NUM_OF_SEL_BITS:0]   cand;
    logic [NUM_OF_MASTER-1:0]   pick_onehot;

    logic normal_release;
    logic ack_seen;
    logic forced_release;
    logic any_release;
    logic do_arbitrate;

    // The current owner is masked out because it is always releasing when
    // arbitration runs from GRANT (GNT_mux is zero in the other states).
    assign eligible    = CYC_I & ~lockout & ~GNT_mux;
    assign pick_onehot = NUM_OF_MASTER'(1) << pick;

    // The bus cycle is only passed through while a master owns the bus.
    assign CYC = (state == GRANT) && CYC_I[GNT];

    // Rotating priority search starting just after the last granted master.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        cand  = '0;
        for (int k = 1; k <= NUM_OF_MASTER; k++) begin
            cand = {1'b0, ptr} + (NUM_OF_SEL_BITS + 1)'(k);
            if (cand >= (NUM_OF_SEL_BITS + 1)'(NUM_OF_MASTER)) begin
                cand = cand - (NUM_OF_SEL_BITS + 1)'(NUM_OF_MASTER);
            end
            if (!found && eligible[cand[NUM_OF_SEL_BITS-1:0]]) begin
                found = 1'b1;
                pick  = cand[NUM_OF_SEL_BITS-1:0];
            end
        end
    end

    // Classify this cycle's event: release beats ACK, ACK beats watchdog expiry.
    always_comb begin
        normal_release = (state == GRANT) && !CYC_I[GNT];
        ack_seen       = (state == GRANT) && CYC_I[GNT] && ACK_I;
        forced_release = (state == GRANT) && CYC_I[GNT] && !ACK_I &&
                         WD_ENABLE && (watchdog == WD_LIMIT);
        any_release    = normal_release || forced_release;
        do_arbitrate   = (state == IDLE) ||
                         ((state == RELEASE) && (drain == 16'd0)) ||
                         (any_release && NO_DRAIN);
    end

    // Arbiter state machine with registered grants, watchdog and drain timer.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state         <= IDLE;
            GNT           <= '0;
            GNT_mux       <= '0;
            timeout       <= 1'b0;
            timeout_count <= 8'd0;
            watchdog      <= 16'd0;
            drain         <= 16'd0;
            lockout       <= '0;
            ptr           <= LAST_MASTER;
        end else begin
            timeout <= forced_release;
            lockout <= (lockout & CYC_I) | (forced_release ? GNT_mux : '0);
            if (forced_release && (timeout_count != 8'hFF)) begin
                timeout_count <= timeout_count + 8'd1;
            end

            if (do_arbitrate) begin
                if (found) begin
                    GNT      <= pick;
                    GNT_mux  <= pick_onehot;
                    ptr      <= pick;
                    watchdog <= 16'd0;
                    state    <= GRANT;
                end else begin
                    GNT_mux <= '0;
                    state   <= IDLE;
                end
            end else if (any_release) begin
                GNT_mux <= '0;
                drain   <= DRAIN_LOAD;
                state   <= RELEASE;
            end else if (state == RELEASE) begin
                drain <= drain - 16'd1;
            end else if (state == GRANT) begin
                if (ack_seen) begin
                    watchdog <= 16'd0;
                end else begin
                    watchdog <= watchdog + 16'd1;
                end
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule
